// File: rtl/result_collector.sv
// Captures one network result, streams each output neuron over a valid/ready port,
// and reports the argmax class on a second valid/ready port.
module result_collector #(
   parameter int NUM_NEURON  = 7,
   parameter int INPUT_SIZE  = 9,
   parameter int NUM_OUTPUTS = 7,
   parameter int IDX_SIZE    = 3
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_NEURON*INPUT_SIZE-1:0] final_output,
   input  logic [NUM_NEURON-1:0]          final_output_valid,
   output logic                           busy,
   output logic [INPUT_SIZE-1:0]          out_value,
   output logic [IDX_SIZE-1:0]            out_index,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [IDX_SIZE-1:0]            class_index,
   output logic [INPUT_SIZE-1:0]          class_value,
   output logic                           class_valid,
   input  logic                           class_ready,
   output logic                           overrun
);

   typedef enum logic [1:0] {IDLE, STREAM, RESULT} state_t;

   localparam logic [IDX_SIZE-1:0] LAST_IDX = IDX_SIZE'(NUM_OUTPUTS - 1);

   state_t                state_reg;
   logic [INPUT_SIZE-1:0] lane_val [NUM_OUTPUTS];
   logic [INPUT_SIZE-1:0] snap_reg [NUM_OUTPUTS];
   logic [IDX_SIZE-1:0]   idx_reg;
   logic [IDX_SIZE-1:0]   best_idx_reg;
   logic [INPUT_SIZE-1:0] best_val_reg;
   logic                  all_prev_reg;

   logic                  all_valid;
   logic                  trigger;
   logic [IDX_SIZE-1:0]   idx_next;
   logic [INPUT_SIZE-1:0] cur_val;
   logic                  take_new;
   logic [IDX_SIZE-1:0]   best_idx_next;
   logic [INPUT_SIZE-1:0] best_val_next;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_lane
         assign lane_val[gi] = final_output[gi*INPUT_SIZE +: INPUT_SIZE];
      end
      if (NUM_OUTPUTS < NUM_NEURON) begin : g_hi_lanes
         // Lanes beyond the last layer's width carry nothing this block needs.
         logic unused_hi_lanes;
         assign unused_hi_lanes = ^{final_output[NUM_NEURON*INPUT_SIZE-1:NUM_OUTPUTS*INPUT_SIZE],
                                    final_output_valid[NUM_NEURON-1:NUM_OUTPUTS]};
      end
   endgenerate

   assign all_valid = &final_output_valid[NUM_OUTPUTS-1:0];
   assign trigger   = all_valid & ~all_prev_reg;
   assign overrun   = trigger & (state_reg != IDLE);

   assign idx_next = idx_reg + IDX_SIZE'(1);
   assign cur_val  = snap_reg[idx_reg];
   // Strict compare so that ties keep the lowest lane index.
   assign take_new      = (idx_reg == '0) || (cur_val > best_val_reg);
   assign best_val_next = take_new ? cur_val : best_val_reg;
   assign best_idx_next = take_new ? idx_reg : best_idx_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         all_prev_reg <= 1'b0;
         idx_reg      <= '0;
         best_idx_reg <= '0;
         best_val_reg <= '0;
         for (int i = 0; i < NUM_OUTPUTS; i++) snap_reg[i] <= '0;
         busy         <= 1'b0;
         out_value    <= '0;
         out_index    <= '0;
         out_valid    <= 1'b0;
         class_index  <= '0;
         class_value  <= '0;
         class_valid  <= 1'b0;
      end else begin
         all_prev_reg <= all_valid;
         case (state_reg)
            IDLE: begin
               if (trigger) begin
                  for (int i = 0; i < NUM_OUTPUTS; i++) snap_reg[i] <= lane_val[i];
                  idx_reg      <= '0;
                  best_idx_reg <= '0;
                  best_val_reg <= '0;
                  busy         <= 1'b1;
                  out_valid    <= 1'b1;
                  out_index    <= '0;
                  out_value    <= lane_val[0];
                  state_reg    <= STREAM;
               end
            end
            STREAM: begin
               if (out_valid && out_ready) begin
                  best_val_reg <= best_val_next;
                  best_idx_reg <= best_idx_next;
                  if (idx_reg == LAST_IDX) begin
                     out_valid   <= 1'b0;
                     class_valid <= 1'b1;
                     class_index <= best_idx_next;
                     class_value <= best_val_next;
                     state_reg   <= RESULT;
                  end else begin
                     idx_reg   <= idx_next;
                     out_index <= idx_next;
                     out_value <= snap_reg[idx_next];
                  end
               end
            end
            RESULT: begin
               if (class_valid && class_ready) begin
                  class_valid <= 1'b0;
                  busy        <= 1'b0;
                  state_reg   <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: streaming, backpressure, overrun,
// retrigger rules, async reset abort and a reduced NUM_OUTPUTS instance.
module tb_result_collector;

   logic        clk = 1'b0;
   logic        rst;
   logic [62:0] fo;
   logic [6:0]  fv;
   logic        out_ready, class_ready;
   logic        busy, out_valid, class_valid, overrun;
   logic [8:0]  out_value, class_value;
   logic [2:0]  out_index, class_index;

   logic [62:0] fo3;
   logic [6:0]  fv3;
   logic        out_ready_3, class_ready_3;
   logic        busy_3, out_valid_3, class_valid_3, overrun_3;
   logic [8:0]  out_value_3, class_value_3;
   logic [2:0]  out_index_3, class_index_3;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] exp_data [7];
   logic [8:0] d1 [7];
   logic [8:0] d3 [7];
   int         ready_pat [6];

   always #5 clk = ~clk;

   result_collector #(.NUM_NEURON(7), .INPUT_SIZE(9), .NUM_OUTPUTS(7), .IDX_SIZE(3)) u_dut (
      .clk(clk), .rst(rst), .final_output(fo), .final_output_valid(fv),
      .busy(busy), .out_value(out_value), .out_index(out_index), .out_valid(out_valid),
      .out_ready(out_ready), .class_index(class_index), .class_value(class_value),
      .class_valid(class_valid), .class_ready(class_ready), .overrun(overrun)
   );

   result_collector #(.NUM_NEURON(7), .INPUT_SIZE(9), .NUM_OUTPUTS(3), .IDX_SIZE(3)) u_dut3 (
      .clk(clk), .rst(rst), .final_output(fo3), .final_output_valid(fv3),
      .busy(busy_3), .out_value(out_value_3), .out_index(out_index_3), .out_valid(out_valid_3),
      .out_ready(out_ready_3), .class_index(class_index_3), .class_value(class_value_3),
      .class_valid(class_valid_3), .class_ready(class_ready_3), .overrun(overrun_3)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pack_lanes(input logic [8:0] d [7]);
      for (int i = 0; i < 7; i++) fo[i*9 +: 9] = d[i];
   endtask

   // Raise all valids; the capture happens on the next rising edge.
   task automatic fire(input logic [8:0] d [7], input bit hold);
      pack_lanes(d);
      fv = 7'h7f;
      @(negedge clk);
      if (!hold) fv = 7'h00;
   endtask

   // Called just after the negedge where beat 0 is already presented.
   task automatic run_stream(input int mode, input int ov_at, input int stop_after,
                             input logic [2:0] exp_ci, input logic [8:0] exp_cv);
      int  beats = 0;
      int  cyc   = 0;
      bit  ov_done = 0;
      bit  ov_chk  = 0;
      while (beats < stop_after && cyc < 100) begin
         check_eq("out_valid", out_valid, 1);
         check_eq("busy", busy, 1);
         check_eq("out_index", out_index, beats);
         check_eq("out_value", out_value, exp_data[beats]);
         if (ov_chk) begin
            #1 check_eq("overrun_drop", overrun, 0);
            ov_chk = 0;
         end
         out_ready = (mode == 0) ? 1'b1 : ready_pat[cyc % 6][0];
         if (beats == ov_at && !ov_done) begin
            pack_lanes(d3);
            fv = 7'h7f;
            #1 check_eq("overrun_pulse", overrun, 1);
            ov_done = 1;
            ov_chk  = 1;
         end
         if (out_ready) beats++;
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b0;
      check_eq("beat_count", beats, stop_after);
      if (stop_after == 7) begin
         check_eq("out_valid_end", out_valid, 0);
         check_eq("class_valid", class_valid, 1);
         check_eq("class_index", class_index, exp_ci);
         check_eq("class_value", class_value, exp_cv);
         @(negedge clk);
         check_eq("class_hold_valid", class_valid, 1);
         check_eq("class_hold_index", class_index, exp_ci);
         check_eq("class_hold_value", class_value, exp_cv);
         class_ready = 1'b1;
         @(negedge clk);
         class_ready = 1'b0;
         check_eq("class_valid_clr", class_valid, 0);
         check_eq("busy_clr", busy, 0);
      end
   endtask

   initial begin
      d1 = '{9'd10, 9'd200, 9'd30, 9'd200, 9'd5, 9'd0, 9'd100};
      d3 = '{9'd50, 9'd7, 9'd300, 9'd12, 9'd300, 9'd1, 9'd299};
      ready_pat = '{1, 0, 0, 1, 0, 1};
      rst = 1'b1;
      fo = '0; fv = '0; out_ready = 1'b0; class_ready = 1'b0;
      fo3 = '0; fv3 = '0; out_ready_3 = 1'b1; class_ready_3 = 1'b0;

      // Reset state
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_value", out_value, 0);
      check_eq("rst_class_valid", class_valid, 0);
      check_eq("rst_overrun", overrun, 0);
      rst = 1'b0;
      @(negedge clk);

      // 1: full-rate stream
      exp_data = d1;
      fire(d1, 0);
      run_stream(0, -1, 7, 3'd1, 9'd200);

      // 2: backpressure pattern
      @(negedge clk);
      fire(d1, 0);
      run_stream(1, -1, 7, 3'd1, 9'd200);

      // 3: new valid rise during beat 3 is dropped; fv stays high afterwards
      @(negedge clk);
      fire(d1, 0);
      run_stream(0, 3, 7, 3'd1, 9'd200);

      // 4: level held high never retriggers; a fall then rise does
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("held_no_busy", busy, 0);
         check_eq("held_no_valid", out_valid, 0);
      end
      fv = 7'h00;
      @(negedge clk);
      exp_data = d3;
      fire(d3, 1);
      run_stream(0, -1, 7, 3'd2, 9'd300);
      fv = 7'h00;

      // 5: async reset after beat 3 accepted, then restart
      @(negedge clk);
      exp_data = d1;
      fire(d1, 0);
      run_stream(0, -1, 4, 3'd0, 9'd0);
      rst = 1'b1;
      #1;
      check_eq("abort_busy", busy, 0);
      check_eq("abort_out_valid", out_valid, 0);
      check_eq("abort_out_index", out_index, 0);
      check_eq("abort_out_value", out_value, 0);
      check_eq("abort_class_valid", class_valid, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      fire(d1, 0);
      run_stream(0, -1, 7, 3'd1, 9'd200);

      // 6: NUM_OUTPUTS=3 instance, upper lanes ignored
      for (int i = 0; i < 7; i++) fo3[i*9 +: 9] = 9'd511;
      fo3[0 +: 9]  = 9'd4;
      fo3[9 +: 9]  = 9'd9;
      fo3[18 +: 9] = 9'd9;
      fv3 = 7'b1111000;
      @(negedge clk);
      @(negedge clk);
      check_eq("n3_upper_ignored", busy_3, 0);
      check_eq("n3_no_valid", out_valid_3, 0);
      fv3 = 7'h7f;
      @(negedge clk);
      check_eq("n3_v0", out_valid_3, 1);
      check_eq("n3_i0", out_index_3, 0);
      check_eq("n3_d0", out_value_3, 4);
      @(negedge clk);
      check_eq("n3_i1", out_index_3, 1);
      check_eq("n3_d1", out_value_3, 9);
      @(negedge clk);
      check_eq("n3_i2", out_index_3, 2);
      check_eq("n3_d2", out_value_3, 9);
      @(negedge clk);
      check_eq("n3_out_valid_end", out_valid_3, 0);
      check_eq("n3_class_valid", class_valid_3, 1);
      check_eq("n3_class_index", class_index_3, 1);
      check_eq("n3_class_value", class_value_3, 9);
      class_ready_3 = 1'b1;
      @(negedge clk);
      check_eq("n3_class_clr", class_valid_3, 0);
      check_eq("n3_busy_clr", busy_3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
